// File: rtl/trng_collect_pkg.sv
// Shared defaults and von Neumann pair encodings for the TRNG bit collector.
package trng_collect_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  // Pair encoding is {first_sample, second_sample}.
  localparam logic [1:0] VN_PAIR_01 = 2'b01;
  localparam logic [1:0] VN_PAIR_10 = 2'b10;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs strobed samples, emits the first sample of a 01/10 pair.
// In bypass mode every strobed sample is emitted directly.
module trng_vn_debias
  import trng_collect_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic strobe_i,
  input  logic sample_i,
  input  logic bypass_i,
  output logic emit_o,
  output logic emit_bit_o
);

  logic       pend_q, pend_d;
  logic       first_q, first_d;
  logic [1:0] pair;

  always_comb begin
    pair       = {first_q, sample_i};
    pend_d     = pend_q;
    first_d    = first_q;
    emit_o     = 1'b0;
    emit_bit_o = 1'b0;
    if (clr_i) begin
      pend_d  = 1'b0;
      first_d = 1'b0;
    end else if (bypass_i) begin
      // A pending first sample is dropped as soon as bypass is selected.
      pend_d     = 1'b0;
      emit_o     = strobe_i;
      emit_bit_o = sample_i;
    end else if (strobe_i) begin
      if (!pend_q) begin
        pend_d  = 1'b1;
        first_d = sample_i;
      end else begin
        pend_d     = 1'b0;
        emit_o     = (pair == VN_PAIR_01) || (pair == VN_PAIR_10);
        emit_bit_o = first_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/trng_bit_collector.sv
// Subsamples the synchronized entropy bit, optionally debiases it, and packs
// the result MSB-first into words offered on a valid/ready port.
module trng_bit_collector
  import trng_collect_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  sample_cnt,
  input  logic              vn_bypass,
  input  logic              rnd_bit_sync,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int              BC_W     = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

  // Handshake: a word transfers on every cycle with word_valid & word_ready;
  // word_data holds steady while word_valid is high and no transfer occurs.

  logic [CNT_W-1:0]  cnt_q, cnt_d, reload, eff_cnt;
  logic              armed_q, armed_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              strobe, emit, emit_bit, complete, xfer, ovf_set;

  trng_vn_debias u_vn (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (~enable),
    .strobe_i   (strobe),
    .sample_i   (rnd_bit_sync),
    .bypass_i   (vn_bypass),
    .emit_o     (emit),
    .emit_bit_o (emit_bit)
  );

  always_comb begin
    reload   = (sample_cnt == '0) ? '0 : sample_cnt - CNT_W'(1);
    // Until the counter has been loaded once after a clear, use the reload value,
    // so the first strobe lands max(sample_cnt,1) cycles after enable.
    eff_cnt  = armed_q ? cnt_q : reload;
    strobe   = enable && (eff_cnt == '0);
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    if (!enable) begin
      cnt_d    = '0;
      armed_d  = 1'b0;
      bitcnt_d = '0;
      shreg_d  = '0;
    end else begin
      armed_d = 1'b1;
      cnt_d   = strobe ? reload : eff_cnt - CNT_W'(1);
      if (emit) begin
        shreg_d = {shreg_q[WORD_W-2:0], emit_bit};
        if (bitcnt_q == LAST_BIT) begin
          complete = 1'b1;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + BC_W'(1);
        end
      end
    end

    xfer    = valid_q & word_ready;
    hold_d  = hold_q;
    valid_d = valid_q;
    ovf_set = 1'b0;
    if (complete) begin
      if (!valid_q || xfer) begin
        hold_d  = shreg_d;
        valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign word_data  = hold_q;
  assign word_valid = valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Directed bench for trng_bit_collector: expected words are queued by the
// stimulus and checked by a monitor on every valid/ready transfer.
module tb_trng_bit_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sample_cnt;
  logic        vn_bypass;
  logic        rnd_bit_sync;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        ovf;
  logic        ovf_clr;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  trng_bit_collector #(.WORD_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_cnt   (sample_cnt),
    .vn_bypass    (vn_bypass),
    .rnd_bit_sync (rnd_bit_sync),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive the top n bits of w, MSB first, one bit per cycle.
  task automatic feed_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      rnd_bit_sync = w[31-i];
      tick();
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: got %h, expected no word", word_data);
      end else begin
        chk("xfer_word", word_data, exp_q.pop_front());
      end
    end
  end

  logic vn_pat[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; sample_cnt = 16'd1; vn_bypass = 1'b1;
    rnd_bit_sync = 1'b0; word_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_data", word_data, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);

    // Bypass, interval 1, alternating bits, always ready
    word_ready = 1'b1;
    exp_q.push_back(32'hAAAAAAAA);
    exp_q.push_back(32'hAAAAAAAA);
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rnd_bit_sync = (i % 2 == 0);
      tick();
      if (i == 30) chk("alt_valid_before", {31'b0, word_valid}, 32'd0);
      if (i == 31) chk("alt_valid_at32", {31'b0, word_valid}, 32'd1);
      if (i == 32) chk("alt_valid_pulse", {31'b0, word_valid}, 32'd0);
    end
    enable = 1'b0;
    tick();
    chk("alt_ovf", {31'b0, ovf}, 32'd0);

    // Bypass, interval 4, constant ones
    sample_cnt = 16'd4;
    rnd_bit_sync = 1'b1;
    exp_q.push_back(32'hFFFFFFFF);
    enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!word_valid && n < 300);
    chk("int4_first_valid_cycle", n, 128);
    enable = 1'b0;
    tick();

    // Von Neumann, interval 1
    sample_cnt = 16'd1;
    vn_bypass = 1'b0;
    exp_q.push_back(32'h55555555);
    enable = 1'b1;
    for (int i = 0; i < 128; i++) begin
      rnd_bit_sync = vn_pat[i % 8];
      tick();
      if (i == 122) chk("vn_valid_before", {31'b0, word_valid}, 32'd0);
      if (i == 123) chk("vn_valid_at", {31'b0, word_valid}, 32'd1);
    end
    enable = 1'b0;
    tick();

    // Back-pressure: overflow, set-wins, clear
    vn_bypass = 1'b1;
    word_ready = 1'b0;
    exp_q.push_back(32'h12345678);
    enable = 1'b1;
    feed_bits(32'h12345678, 32);
    chk("bp_valid", {31'b0, word_valid}, 32'd1);
    chk("bp_ovf_first", {31'b0, ovf}, 32'd0);
    feed_bits(32'hDEADBEEF, 32);
    chk("bp_ovf_set", {31'b0, ovf}, 32'd1);
    chk("bp_data_kept", word_data, 32'h12345678);
    feed_bits(32'h0BADCAFE, 31);
    rnd_bit_sync = 1'b0;
    ovf_clr = 1'b1;
    tick();
    chk("bp_ovf_set_wins", {31'b0, ovf}, 32'd1);
    chk("bp_data_kept2", word_data, 32'h12345678);
    enable = 1'b0;
    tick();
    chk("bp_ovf_cleared", {31'b0, ovf}, 32'd0);
    ovf_clr = 1'b0;
    word_ready = 1'b1;
    tick();
    chk("bp_valid_drained", {31'b0, word_valid}, 32'd0);

    // Completion coincident with transfer
    word_ready = 1'b0;
    exp_q.push_back(32'hCAFEF00D);
    exp_q.push_back(32'h0F1E2D3C);
    enable = 1'b1;
    feed_bits(32'hCAFEF00D, 32);
    feed_bits(32'h0F1E2D3C, 31);
    rnd_bit_sync = 1'b0;
    word_ready = 1'b1;
    tick();
    chk("coin_valid", {31'b0, word_valid}, 32'd1);
    chk("coin_data", word_data, 32'h0F1E2D3C);
    chk("coin_ovf", {31'b0, ovf}, 32'd0);
    enable = 1'b0;
    tick();
    chk("coin_drained", {31'b0, word_valid}, 32'd0);

    // Partial word discarded by a one-cycle disable
    enable = 1'b1;
    feed_bits(32'hFFFFFFFF, 10);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    exp_q.push_back(32'h13579BDF);
    feed_bits(32'h13579BDF, 32);
    enable = 1'b0;
    tick();
    chk("partial_drained", {31'b0, word_valid}, 32'd0);

    // Reset while a word is held
    word_ready = 1'b0;
    enable = 1'b1;
    feed_bits(32'h89ABCDEF, 32);
    chk("rst_mid_valid_pre", {31'b0, word_valid}, 32'd1);
    enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_mid_data", word_data, 32'd0);
    word_ready = 1'b1;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
